// File: rtl/acumulador_produtos.sv
// Sums N consecutive unsigned products from the multiplier and presents each block sum
// on a valid/ready port, stalling intake while an untaken sum is pending.
module acumulador_produtos #(
    parameter int unsigned TAM   = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned ACC_W = 2 * TAM + 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               P_valid,
    input  logic [2*TAM-1:0]   P,
    output logic               P_ready,
    output logic [ACC_W-1:0]   soma,
    output logic               soma_valid,
    input  logic               soma_ready,
    output logic               ovf
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    typedef enum logic {StAcum, StSaida} state_e;

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CntW-1:0]    cnt_q;
    logic               ovf_acc_q;
    logic [ACC_W-1:0]   soma_q;
    logic               soma_valid_q;
    logic               ovf_q;

    // One extra bit catches the carry out of the accumulator MSB.
    logic [ACC_W:0]     sum_w;
    logic               carry_w;

    assign sum_w   = {1'b0, acc_q} + {{(ACC_W + 1 - 2 * TAM){1'b0}}, P};
    assign carry_w = sum_w[ACC_W];

    assign P_ready    = (state_q == StAcum);
    assign soma       = soma_q;
    assign soma_valid = soma_valid_q;
    assign ovf        = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StAcum;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_acc_q    <= 1'b0;
            soma_q       <= '0;
            soma_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else if (clr) begin
            state_q      <= StAcum;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_acc_q    <= 1'b0;
            soma_q       <= '0;
            soma_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StAcum: begin
                    if (P_valid) begin
                        if (cnt_q == CntLast) begin
                            soma_q       <= sum_w[ACC_W-1:0];
                            ovf_q        <= ovf_acc_q | carry_w;
                            soma_valid_q <= 1'b1;
                            acc_q        <= '0;
                            cnt_q        <= '0;
                            ovf_acc_q    <= 1'b0;
                            state_q      <= StSaida;
                        end else begin
                            acc_q     <= sum_w[ACC_W-1:0];
                            cnt_q     <= cnt_q + 1'b1;
                            ovf_acc_q <= ovf_acc_q | carry_w;
                        end
                    end
                end
                StSaida: begin
                    // soma and ovf keep their values after the take.
                    if (soma_ready) begin
                        soma_valid_q <= 1'b0;
                        state_q      <= StAcum;
                    end
                end
                default: state_q <= StAcum;
            endcase
        end
    end

endmodule

// File: tb/tb_acumulador_produtos.sv
// Scoreboard bench: expected block sums are queued by the stimulus and popped by
// per-instance monitors whenever a sum is taken.
module tb_acumulador_produtos;

    typedef struct packed {
        logic [19:0] soma;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        b_clr;

    logic        a_pv, a_pr, a_sv, a_sr, a_ovf;
    logic [15:0] a_p;
    logic [19:0] a_soma;

    logic        b_pv, b_pr, b_sv, b_sr, b_ovf;
    logic [15:0] b_p;
    logic [15:0] b_soma;

    int vectors;
    int miscompares;
    exp_t q_a[$];
    exp_t q_b[$];

    acumulador_produtos #(.TAM(8), .N(4), .ACC_W(20)) u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .P_valid    (a_pv),
        .P          (a_p),
        .P_ready    (a_pr),
        .soma       (a_soma),
        .soma_valid (a_sv),
        .soma_ready (a_sr),
        .ovf        (a_ovf)
    );

    acumulador_produtos #(.TAM(8), .N(2), .ACC_W(16)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (b_clr),
        .P_valid    (b_pv),
        .P          (b_p),
        .P_ready    (b_pr),
        .soma       (b_soma),
        .soma_valid (b_sv),
        .soma_ready (b_sr),
        .ovf        (b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: a take happens on the next rising edge when valid & ready at the falling edge.
    always @(negedge clk) begin
        if (rst_n && !clr && a_sv && a_sr) begin
            if (q_a.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL a_unexpected_sum: got 0x%0h, expected none", a_soma);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_soma", 32'(a_soma), 32'(e.soma));
                chk("a_ovf", 32'(a_ovf), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_sv && b_sr) begin
            if (q_b.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL b_unexpected_sum: got 0x%0h, expected none", b_soma);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_soma", 32'(b_soma), 32'(e.soma));
                chk("b_ovf", 32'(b_ovf), 32'(e.ovf));
            end
        end
    end

    task automatic push_a(input logic [19:0] s, input logic o);
        exp_t e;
        e.soma = s;
        e.ovf  = o;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [19:0] s, input logic o);
        exp_t e;
        e.soma = s;
        e.ovf  = o;
        q_b.push_back(e);
    endtask

    // Present p until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input bit sel, input logic [15:0] p);
        int n;
        n = 0;
        if (sel) begin b_pv = 1'b1; b_p = p; end
        else     begin a_pv = 1'b1; a_p = p; end
        @(negedge clk);
        while (!(sel ? b_pr : a_pr) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(sel ? b_pr : a_pr)) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got P_ready=0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        if (sel) b_pv = 1'b0;
        else     a_pv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0; clr = 1'b0; b_clr = 1'b0;
        a_pv = 1'b0; a_p = '0; a_sr = 1'b1;
        b_pv = 1'b0; b_p = '0; b_sr = 1'b1;
        #12;
        chk("rst_a_soma", 32'(a_soma), 32'h0);
        chk("rst_a_valid", 32'(a_sv), 32'h0);
        chk("rst_a_ovf", 32'(a_ovf), 32'h0);
        chk("rst_a_pready", 32'(a_pr), 32'h1);
        chk("rst_b_valid", 32'(b_sv), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Basic block, P_ready low for exactly one cycle.
        push_a(20'd10, 1'b0);
        send(0, 16'd1); send(0, 16'd2); send(0, 16'd3); send(0, 16'd4);
        @(negedge clk);
        chk("t1_pready_low", 32'(a_pr), 32'h0);
        chk("t1_valid_high", 32'(a_sv), 32'h1);
        @(negedge clk);
        chk("t1_pready_back", 32'(a_pr), 32'h1);
        idle(1);

        // Maximal products, no wrap in 20 bits.
        push_a(20'h3F804, 1'b0);
        repeat (4) send(0, 16'hFE01);
        idle(2);

        // Backpressure with a product held valid during the stall.
        a_sr = 1'b0;
        push_a(20'd100, 1'b0);
        send(0, 16'd10); send(0, 16'd20); send(0, 16'd30); send(0, 16'd40);
        a_pv = 1'b1; a_p = 16'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_soma", 32'(a_soma), 32'd100);
            chk("t3_stall_pready", 32'(a_pr), 32'h0);
            chk("t3_stall_valid", 32'(a_sv), 32'h1);
        end
        @(posedge clk); #1;
        a_sr = 1'b1;
        push_a(20'd28, 1'b0);
        repeat (4) send(0, 16'd7);
        idle(2);

        // Gapped valid.
        push_a(20'd26, 1'b0);
        send(0, 16'd5); idle(2);
        send(0, 16'd6); idle(2);
        send(0, 16'd7); idle(2);
        send(0, 16'd8);
        idle(3);

        // Overflow on the N=2, 16-bit instance; flag clears for the next block.
        push_b(20'h0, 1'b1);
        send(1, 16'hFFFF); send(1, 16'h0001);
        idle(2);
        push_b(20'd2, 1'b0);
        send(1, 16'd1); send(1, 16'd1);
        idle(2);

        // Clear mid-block, then a clean block.
        send(0, 16'd3); send(0, 16'd3);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("t6_clr_soma", 32'(a_soma), 32'h0);
        chk("t6_clr_ovf", 32'(a_ovf), 32'h0);
        chk("t6_clr_valid", 32'(a_sv), 32'h0);
        push_a(20'd12, 1'b0);
        repeat (4) send(0, 16'd3);
        idle(2);
        chk("t6_soma_held", 32'(a_soma), 32'd12);

        // Async reset mid-block clears outputs with no clock edge.
        send(0, 16'd3); send(0, 16'd3);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_soma", 32'(a_soma), 32'h0);
        chk("t6_async_pready", 32'(a_pr), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        push_a(20'd12, 1'b0);
        repeat (4) send(0, 16'd3);
        idle(3);

        chk("end_q_a_empty", 32'(q_a.size()), 32'h0);
        chk("end_q_b_empty", 32'(q_b.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
